// File: rtl/vision_pkg.sv
// Shared vision-pipeline constants and the centre-of-mass tracker state type.
package vision_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } com_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, WIDTH cycles per divide.
// A start_in while busy is ignored; valid_out pulses for one cycle with the result.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             valid_out,
    output logic             busy_out
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    step_q;
    logic             busy_q;
    logic             valid_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             fits;

    // The dividend is shifted out of quot_q MSB-first while quotient bits fill in from the LSB.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        fits      = (rem_shift >= {1'b0, divisor_q});
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            quot_q    <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_in && !busy_q) begin
                quot_q    <= dividend_in;
                divisor_q <= divisor_in;
                rem_q     <= '0;
                step_q    <= '0;
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= fits ? rem_sub : rem_shift;
                quot_q <= {quot_q[WIDTH-2:0], fits};
                step_q <= step_q + CW'(1);
                if (step_q == CW'(WIDTH - 1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_out  = quot_q;
    assign remainder_out = rem_q[WIDTH-1:0];
    assign valid_out     = valid_q;
    assign busy_out      = busy_q;

endmodule

// File: rtl/com_tracker.sv
// Per-frame centre-of-mass tracker: sums mask-true pixel coordinates, divides by count on frame end.
// Optional build macro COM_TRACKER_SMOOTH_EN averages each new centroid with the previous output.
module com_tracker
    import vision_pkg::*;
#(
    parameter int HCOUNT_W   = vision_pkg::HCOUNT_W,
    parameter int VCOUNT_W   = vision_pkg::VCOUNT_W,
    parameter int SUM_W      = 32,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [HCOUNT_W-1:0] x_in,
    input  logic [VCOUNT_W-1:0] y_in,
    input  logic                valid_in,
    input  logic                tabulate_in,
    output logic [HCOUNT_W-1:0] x_out,
    output logic [VCOUNT_W-1:0] y_out,
    output logic                valid_out,
    output logic                busy_out
);

    com_state_t state, next_state;

    logic [SUM_W-1:0]    x_sum, y_sum;
    logic [CNT_W-1:0]    count;
    logic                accept, enough, div_start;
    logic [SUM_W-1:0]    x_quot, y_quot, x_rem, y_rem;
    logic                x_div_valid, y_div_valid, x_div_busy, y_div_busy;
    logic [HCOUNT_W-1:0] x_next;
    logic [VCOUNT_W-1:0] y_next;
    logic                unused_div;

    assign accept    = (state == ACCUM) && tabulate_in;
    assign enough    = (count != '0) && (count >= CNT_W'(MIN_PIXELS));
    assign div_start = accept && enough;

    // A pixel coinciding with an accepted tabulate is the first pixel of the next frame.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            x_sum <= '0;
            y_sum <= '0;
            count <= '0;
        end else if (accept) begin
            x_sum <= valid_in ? SUM_W'(x_in) : '0;
            y_sum <= valid_in ? SUM_W'(y_in) : '0;
            count <= valid_in ? CNT_W'(1) : '0;
        end else if (valid_in) begin
            x_sum <= x_sum + SUM_W'(x_in);
            y_sum <= y_sum + SUM_W'(y_in);
            count <= count + CNT_W'(1);
        end
    end

    seq_divider #(.WIDTH(SUM_W)) u_x_div (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (div_start),
        .dividend_in   (x_sum),
        .divisor_in    (SUM_W'(count)),
        .quotient_out  (x_quot),
        .remainder_out (x_rem),
        .valid_out     (x_div_valid),
        .busy_out      (x_div_busy)
    );

    seq_divider #(.WIDTH(SUM_W)) u_y_div (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (div_start),
        .dividend_in   (y_sum),
        .divisor_in    (SUM_W'(count)),
        .quotient_out  (y_quot),
        .remainder_out (y_rem),
        .valid_out     (y_div_valid),
        .busy_out      (y_div_busy)
    );

    assign unused_div = ^{x_rem, y_rem, x_div_busy, y_div_busy,
                          x_quot[SUM_W-1:HCOUNT_W], y_quot[SUM_W-1:VCOUNT_W]};

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (div_start) next_state = DIVIDE;
            DIVIDE:  if (x_div_valid && y_div_valid) next_state = DONE;
            DONE:    next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

`ifdef COM_TRACKER_SMOOTH_EN
    logic                first_q;
    logic [HCOUNT_W:0]   x_avg;
    logic [VCOUNT_W:0]   y_avg;

    // The first centroid after reset has no history, so it loads unfiltered.
    always_comb begin
        x_avg  = {1'b0, x_out} + {1'b0, x_quot[HCOUNT_W-1:0]};
        y_avg  = {1'b0, y_out} + {1'b0, y_quot[VCOUNT_W-1:0]};
        x_next = first_q ? x_quot[HCOUNT_W-1:0] : x_avg[HCOUNT_W:1];
        y_next = first_q ? y_quot[VCOUNT_W-1:0] : y_avg[VCOUNT_W:1];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            first_q <= 1'b1;
        end else if (state == DONE) begin
            first_q <= 1'b0;
        end
    end
`else
    assign x_next = x_quot[HCOUNT_W-1:0];
    assign y_next = y_quot[VCOUNT_W-1:0];
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            x_out     <= '0;
            y_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (state == DONE) begin
                x_out     <= x_next;
                y_out     <= y_next;
                valid_out <= 1'b1;
            end
        end
    end

    assign busy_out = (state == DIVIDE);

endmodule

// File: tb/tb_com_tracker.sv
// Directed bench for com_tracker at default parameters (MIN_PIXELS=16, result 34 cycles after tabulate).
// Expected centroids come from hand-computed sums; COM_TRACKER_SMOOTH_EN switches the bench's filter model.
module tb_com_tracker;

    localparam int LATENCY = 34;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic        tabulate_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        busy_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int tab_cyc = 0;
    int pulse_cyc = 0;
    int pulse_cnt = 0;
    int exp_x = 0;
    int exp_y = 0;
    bit model_first = 1'b1;
    int lat;
    int pulses_before;

    always #5 clk_in = ~clk_in;

    com_tracker dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .valid_in    (valid_in),
        .tabulate_in (tabulate_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic applyStimulus(input int x, input int y, input logic v, input logic t);
        @(negedge clk_in);
        x_in        = x[10:0];
        y_in        = y[9:0];
        valid_in    = v;
        tabulate_in = t;
        @(posedge clk_in);
        #1;
        cyc++;
        if (valid_out === 1'b1) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0, 1'b0);
    endtask

    task automatic sendPixels(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) applyStimulus(x, y, 1'b1, 1'b0);
    endtask

    task automatic tabulateFrame();
        applyStimulus(0, 0, 1'b0, 1'b1);
        tab_cyc = cyc;
    endtask

    task automatic modelReset();
        exp_x       = 0;
        exp_y       = 0;
        model_first = 1'b1;
    endtask

    task automatic expectCentroid(input int qx, input int qy);
`ifdef COM_TRACKER_SMOOTH_EN
        if (model_first) begin
            exp_x = qx;
            exp_y = qy;
        end else begin
            exp_x = (exp_x + qx) >> 1;
            exp_y = (exp_y + qy) >> 1;
        end
`else
        exp_x = qx;
        exp_y = qy;
`endif
        model_first = 1'b0;
    endtask

    // Waits a bounded number of cycles for a valid_out pulse; -1 latency means none arrived.
    task automatic waitValid(output int l);
        int start;
        start = pulse_cnt;
        for (int n = 0; n < 2 * LATENCY && pulse_cnt == start; n++) idle(1);
        l = (pulse_cnt != start) ? (pulse_cyc - tab_cyc) : -1;
    endtask

    task automatic checkResult(input string tag);
        waitValid(lat);
        checkOutput({tag, "_latency"}, lat, LATENCY);
        checkOutput({tag, "_x"}, int'(x_out), exp_x);
        checkOutput({tag, "_y"}, int'(y_out), exp_y);
        idle(1);
        checkOutput({tag, "_pulse_width"}, int'(valid_out), 0);
        checkOutput({tag, "_busy_after"}, int'(busy_out), 0);
    endtask

    initial begin
        // Reset state
        rst_in = 1'b0;
        idle(3);
        checkOutput("reset_x", int'(x_out), 0);
        checkOutput("reset_y", int'(y_out), 0);
        checkOutput("reset_valid", int'(valid_out), 0);
        checkOutput("reset_busy", int'(busy_out), 0);
        rst_in = 1'b1;
        modelReset();
        idle(2);

        // Two-point frame: sums 320/480 over 16 pixels
        sendPixels(10, 20, 8);
        sendPixels(30, 40, 8);
        tabulateFrame();
        checkOutput("frameA_busy", int'(busy_out), 1);
        expectCentroid(20, 30);
        checkResult("frameA");

        // Floor division: x 12/18 and y 6/18 both floor to 0
        for (int r = 0; r < 6; r++) begin
            sendPixels(0, 0, 1);
            sendPixels(1, 0, 1);
            sendPixels(1, 1, 1);
        end
        tabulateFrame();
        expectCentroid(0, 0);
        checkResult("frameB");

        // Exactly MIN_PIXELS pixels is accepted
        sendPixels(5, 7, 16);
        tabulateFrame();
        expectCentroid(5, 7);
        checkResult("frameC");

        // One pixel short of MIN_PIXELS is rejected and outputs hold
        sendPixels(9, 9, 15);
        pulses_before = pulse_cnt;
        tabulateFrame();
        checkOutput("short_busy", int'(busy_out), 0);
        idle(2 * LATENCY);
        checkOutput("short_no_pulse", pulse_cnt, pulses_before);
        checkOutput("short_hold_x", int'(x_out), exp_x);
        checkOutput("short_hold_y", int'(y_out), exp_y);

        // Empty frame is rejected
        tabulateFrame();
        checkOutput("empty_busy", int'(busy_out), 0);
        idle(2 * LATENCY);
        checkOutput("empty_no_pulse", pulse_cnt, pulses_before);

        // Second tabulate during the divide is ignored; its pixels carry into the next frame
        sendPixels(8, 4, 16);
        tabulateFrame();
        sendPixels(20, 10, 4);
        applyStimulus(20, 10, 1'b1, 1'b1);
        expectCentroid(8, 4);
        checkResult("merge_first");
        pulses_before = pulse_cnt;
        idle(2 * LATENCY);
        checkOutput("merge_single_pulse", pulse_cnt, pulses_before);
        sendPixels(20, 10, 11);
        tabulateFrame();
        expectCentroid(20, 10);
        checkResult("merge_second");

        // Reset ten cycles into the divide abandons it
        sendPixels(3, 3, 16);
        tabulateFrame();
        idle(10);
        checkOutput("abort_busy_before", int'(busy_out), 1);
        pulses_before = pulse_cnt;
        rst_in = 1'b0;
        idle(2);
        checkOutput("abort_x", int'(x_out), 0);
        checkOutput("abort_y", int'(y_out), 0);
        checkOutput("abort_busy", int'(busy_out), 0);
        rst_in = 1'b1;
        modelReset();
        idle(2 * LATENCY);
        checkOutput("abort_no_pulse", pulse_cnt, pulses_before);

        sendPixels(100, 50, 16);
        tabulateFrame();
        expectCentroid(100, 50);
        checkResult("post_abort");

        // Fresh reset, then two frames that exercise the optional filter
        rst_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
        modelReset();
        idle(1);
        sendPixels(100, 100, 16);
        tabulateFrame();
        expectCentroid(100, 100);
        checkResult("filter_first");
        sendPixels(200, 50, 16);
        tabulateFrame();
        expectCentroid(200, 50);
        checkResult("filter_second");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/com_tracker.md
Name: com_tracker

Overview:
- Per-frame centre-of-mass tracker. Sits directly upstream of the VGA pixel mux.
- Accumulates the coordinates of every thresholded (mask-true) pixel over a frame.
- On the frame-end pulse, divides the sums by the pixel count using a sequential divider.
- Publishes the centroid, which drives the crosshair and sprite-position logic feeding the mux's crosshair/sprite inputs.

Parameters:
- HCOUNT_W, 11, width of the x coordinate
- VCOUNT_W, 10, width of the y coordinate
- SUM_W, 32, width of the x/y coordinate accumulators
- CNT_W, 20, width of the pixel-count accumulator
- MIN_PIXELS, 16, minimum count for the result to be published

Ports:
- clk_in  input  1  system pixel clock
- rst_in  input  1  synchronous, active-low reset
- x_in  input  HCOUNT_W  current pixel x
- y_in  input  VCOUNT_W  current pixel y
- valid_in  input  1  current pixel is mask-true, so accumulate it
- tabulate_in  input  1  one-cycle end-of-frame pulse
- x_out  output  HCOUNT_W  centroid x
- y_out  output  VCOUNT_W  centroid y
- valid_out  output  1  one-cycle pulse when x_out/y_out update
- busy_out  output  1  high while the divide is in progress

Behaviour:
- Reset (rst_in low at a clock edge):
  - x_out=0, y_out=0, valid_out=0, busy_out=0.
  - Accumulators and count cleared; FSM goes to ACCUM.
  - Applies mid-divide too: the divide is abandoned and no valid_out is produced.
- Accumulation (runs in every FSM state):
  - valid_in=1: x_sum+=x_in, y_sum+=y_in, count+=1.
  - Zero-extend inputs; no saturation. Wrap is not expected at the default widths.
- tabulate_in=1 while in ACCUM:
  - Snapshot x_sum, y_sum, count into the divider operand registers.
  - Clear the accumulators in the same cycle. A valid_in pixel arriving in that cycle is the first pixel of the new frame, so sums restart at that pixel.
  - If snapshot count < MIN_PIXELS or count==0: stay in ACCUM; outputs hold, no valid_out.
  - Otherwise go to DIVIDE.
- tabulate_in=1 while in DIVIDE/DONE: ignored. Accumulators are not cleared and keep summing, so that frame merges into the next.
- FSM states:
  - ACCUM: idle, busy_out=0.
  - DIVIDE: busy_out=1. The x and y restoring divides run in parallel, one quotient bit per cycle, SUM_W cycles.
  - DONE: one cycle. Register the quotients into x_out/y_out, truncated to their port widths; valid_out=1; then return to ACCUM.
- Latency: valid_out is asserted exactly SUM_W+2 cycles after the tabulate_in edge (34 at default).
- Quotients: floor division; the remainder is discarded.
- valid_out is high for exactly one cycle per accepted frame.

Optional Feature:
- COM_TRACKER_SMOOTH_EN defined:
  - In DONE, x_out <= (x_out + x_quot) >> 1, and likewise for y, using one extra bit internally.
  - This is a first-order IIR filter that damps crosshair jitter.
  - The first result after reset loads directly, without averaging.
- Not defined: x_out/y_out load the raw quotients.

Decomposition:
- Shared package (vision_pkg) holds:
  - HCOUNT_W/VCOUNT_W constants
  - the com_state_t enum (ACCUM, DIVIDE, DONE)
- One natural sub-module: seq_divider.
  - Parameter WIDTH.
  - Ports: start_in, dividend_in, divisor_in, quotient_out, remainder_out, valid_out, busy_out.
  - Two instances, x and y.
  - Also reusable by the future linear-regression line block.

Test Plan:
- MIN_PIXELS=1. Pixels (10,20) and (30,40), then tabulate -> 34 cycles later valid_out=1, x_out=20, y_out=30.
- Pixels (0,0), (1,0), (1,1), tabulate -> x_out=0 (2/3 floored), y_out=0. Then (5,7)x4, tabulate -> x_out=5, y_out=7.
- MIN_PIXELS=16 with only 15 valid pixels, tabulate -> no valid_out; x_out/y_out keep prior values; FSM stays in ACCUM.
- Second tabulate 5 cycles after the first (during DIVIDE) -> ignored. Pixels fed after the first tabulate accumulate into the next frame's result; only one valid_out pulse results.
- rst_in low 10 cycles into DIVIDE -> no valid_out; x_out=y_out=0, busy_out=0. A fresh frame of (100,50)x16 then yields x_out=100, y_out=50.
- Smooth build (COM_TRACKER_SMOOTH_EN): frame centroid (100,100), then (200,50) -> outputs 100,100 then 150,75.
